dual_slope_ctrl: RTL and testbench
==================================

DUAL_SLOPE_CTRL -- requirements
Module: dual_slope_ctrl

Interface
- REQ-001 Parameter AZ_CYCLES, default 256: auto-zero phase length in clocks; range 1..65535.
- REQ-002 Parameter INT_CYCLES, default 4096: fixed integrate (run-up) phase length in clocks; range 1..65535.
- REQ-003 Parameter MAX_DEINT, default 8191: de-integrate timeout in clocks; range 1..65535.
- REQ-004 clk_i  in  1  sole clock, rising edge.
- REQ-005 rst_ni  in  1  reset, synchronous, active-low.
- REQ-006 start_i  in  1  conversion request, sampled each clock.
- REQ-007 cmp_i  in  1  integrator comparator; 1 = integrator not yet returned to zero.
- REQ-008 sw_az_o  out  1  auto-zero switch enable.
- REQ-009 sw_vin_o  out  1  input-voltage switch enable.
- REQ-010 sw_vref_o  out  1  reference switch enable.
- REQ-011 cnt_clr_o  out  1  clear strobe to downstream counter.
- REQ-012 cnt_en_o  out  1  count enable to downstream counter.
- REQ-013 result_o  out  16  last de-integrate count.
- REQ-014 valid_o  out  1  one-cycle strobe: result_o updated.
- REQ-015 busy_o  out  1  conversion in progress.
- REQ-016 ovr_o  out  1  last conversion hit MAX_DEINT.

Function
- REQ-017 States: IDLE, AZ, GAP1, INT, GAP2, DEINT, DONE.
- REQ-018 IDLE: start_i=1 -> AZ next cycle; cnt_clr_o=1 in the first AZ cycle only.
- REQ-019 start_i while not in IDLE is ignored; it is neither queued nor does it restart.
- REQ-020 AZ: sw_az_o=1 for exactly AZ_CYCLES cycles -> GAP1.
- REQ-021 GAP1 and GAP2 last one cycle each with all three switch outputs 0 (break-before-make).
- REQ-022 INT: sw_vin_o=1 for exactly INT_CYCLES cycles -> GAP2 -> DEINT.
- REQ-023 DEINT: sw_vref_o=1 and cnt_en_o=1; internal 16-bit deint counter starts at 0 and increments once per cycle while the effective comparator is 1.
- REQ-024 DEINT exit: effective comparator=0 -> DONE with result = deint counter, ovr=0.
- REQ-025 DEINT exit: deint counter reaches MAX_DEINT -> DONE with result=MAX_DEINT, ovr=1; this takes priority if it coincides with the comparator falling.
- REQ-026 Comparator already 0 in the first DEINT cycle -> result 0.
- REQ-027 DONE lasts one cycle: valid_o=1, result_o and ovr_o load, all switch and count outputs 0 -> IDLE.
- REQ-028 result_o and ovr_o hold their value until the next DONE.
- REQ-029 At most one of sw_az_o, sw_vin_o, sw_vref_o is 1 in any cycle.
- REQ-030 busy_o=1 in every state except IDLE.
- REQ-031 All outputs are registered.
- REQ-032 The deint counter never wraps; the phase counters are sized to 16 bits.

Reset
- REQ-033 rst_ni=0 at a clock edge -> state IDLE, all outputs 0, result_o=16'h0000, all counters 0.
- REQ-034 Reset asserted mid-conversion aborts it; no valid_o strobe follows, and all switch outputs read 0 from the first cycle after the edge.

Configuration
- REQ-035 Macro DUAL_SLOPE_CMP_SYNC_EN defined: cmp_i passes a 2-flop synchronizer before use, giving 2 cycles of comparator latency; the result includes those 2 cycles.
- REQ-036 Macro undefined: cmp_i is used directly as the effective comparator with 0 added latency.

Structure
- REQ-037 Package dual_slope_pkg holds the state enum and the default AZ/INT/MAX_DEINT constants.
- REQ-038 Sub-module cmp_sync (2-flop synchronizer) is instantiated only under DUAL_SLOPE_CMP_SYNC_EN.

Verification
Bench parameters: AZ=4, INT=8, MAX_DEINT=20; sync macro off unless stated.
- REQ-039 Reset, then a 1-cycle start_i pulse; cmp_i=1 for the first 5 DEINT cycles, then 0 -> sw_az_o high 4 cycles, gap, sw_vin_o high 8 cycles, gap, sw_vref_o high; valid_o pulses with result_o=5, ovr_o=0.
- REQ-040 cmp_i held at 1 -> result_o=20, ovr_o=1, valid_o pulses once.
- REQ-041 cmp_i=0 at DEINT entry -> result_o=0; a new start_i pulse issued during INT -> no effect, and exactly one valid_o.
- REQ-042 rst_ni=0 during INT -> next cycle all outputs 0 and busy_o=0; no valid_o; result_o=0.
- REQ-043 Macro on, same stimulus as REQ-039 -> result_o=7.
- REQ-044 Every run: assert the one-hot/zero switch invariant, and assert busy_o==(state!=IDLE).

Source files
------------

// File: rtl/dual_slope_pkg.sv
// Shared types and default phase lengths for the dual-slope ADC sequencer.
package dual_slope_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AZ,
        S_GAP1,
        S_INT,
        S_GAP2,
        S_DEINT,
        S_DONE
    } state_t;

    localparam int unsigned AZ_CYCLES_DEF  = 256;
    localparam int unsigned INT_CYCLES_DEF = 4096;
    localparam int unsigned MAX_DEINT_DEF  = 8191;

endpackage

// File: rtl/dual_slope_ctrl_cmp_sync.sv
// Two-flop synchronizer for the asynchronous integrator comparator.
module cmp_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dual_slope_ctrl.sv
// Dual-slope ADC sequencer: auto-zero, fixed run-up, timed run-down.
// Optional macro DUAL_SLOPE_CMP_SYNC_EN adds a 2-flop comparator synchronizer.
module dual_slope_ctrl
    import dual_slope_pkg::*;
#(
    parameter int unsigned AZ_CYCLES  = AZ_CYCLES_DEF,
    parameter int unsigned INT_CYCLES = INT_CYCLES_DEF,
    parameter int unsigned MAX_DEINT  = MAX_DEINT_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        cmp_i,
    output logic        sw_az_o,
    output logic        sw_vin_o,
    output logic        sw_vref_o,
    output logic        cnt_clr_o,
    output logic        cnt_en_o,
    output logic [15:0] result_o,
    output logic        valid_o,
    output logic        busy_o,
    output logic        ovr_o
);

    localparam logic [15:0] AZ_LAST  = 16'(AZ_CYCLES - 1);
    localparam logic [15:0] INT_LAST = 16'(INT_CYCLES - 1);
    localparam logic [15:0] DEINT_MAX = 16'(MAX_DEINT);

    state_t      state, state_nxt;
    logic [15:0] phase_cnt, phase_nxt;
    logic [15:0] deint_cnt, deint_nxt;
    logic [15:0] done_res;
    logic        done_ovr;
    logic        cmp_eff;

`ifdef DUAL_SLOPE_CMP_SYNC_EN
    cmp_sync u_cmp_sync (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .d     (cmp_i),
        .q     (cmp_eff)
    );
`else
    assign cmp_eff = cmp_i;
`endif

    always_comb begin
        state_nxt = state;
        phase_nxt = phase_cnt;
        deint_nxt = deint_cnt;
        done_res  = deint_cnt;
        done_ovr  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nxt = S_AZ;
                    phase_nxt = '0;
                end
            end
            S_AZ: begin
                if (phase_cnt == AZ_LAST) begin
                    state_nxt = S_GAP1;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase_cnt + 16'd1;
                end
            end
            S_GAP1: state_nxt = S_INT;
            S_INT: begin
                if (phase_cnt == INT_LAST) begin
                    state_nxt = S_GAP2;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase_cnt + 16'd1;
                end
            end
            S_GAP2: begin
                state_nxt = S_DEINT;
                deint_nxt = '0;
            end
            S_DEINT: begin
                // Timeout wins over a comparator edge landing in the same cycle.
                if (deint_cnt == DEINT_MAX) begin
                    state_nxt = S_DONE;
                    done_res  = DEINT_MAX;
                    done_ovr  = 1'b1;
                end else if (!cmp_eff) begin
                    state_nxt = S_DONE;
                end else begin
                    deint_nxt = deint_cnt + 16'd1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they align with the state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            deint_cnt <= '0;
            sw_az_o   <= 1'b0;
            sw_vin_o  <= 1'b0;
            sw_vref_o <= 1'b0;
            cnt_clr_o <= 1'b0;
            cnt_en_o  <= 1'b0;
            valid_o   <= 1'b0;
            busy_o    <= 1'b0;
            result_o  <= '0;
            ovr_o     <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_nxt;
            deint_cnt <= deint_nxt;
            sw_az_o   <= (state_nxt == S_AZ);
            sw_vin_o  <= (state_nxt == S_INT);
            sw_vref_o <= (state_nxt == S_DEINT);
            cnt_en_o  <= (state_nxt == S_DEINT);
            cnt_clr_o <= (state == S_IDLE) && (state_nxt == S_AZ);
            valid_o   <= (state_nxt == S_DONE);
            busy_o    <= (state_nxt != S_IDLE);
            if (state_nxt == S_DONE) begin
                result_o <= done_res;
                ovr_o    <= done_ovr;
            end
        end
    end

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Directed bench for dual_slope_ctrl with AZ=4, INT=8, MAX_DEINT=20.
module tb_dual_slope_ctrl;
    import dual_slope_pkg::*;

    logic        clk;
    logic        rst_ni;
    logic        start_i;
    logic        cmp_i;
    logic        sw_az_o, sw_vin_o, sw_vref_o;
    logic        cnt_clr_o, cnt_en_o;
    logic [15:0] result_o;
    logic        valid_o, busy_o, ovr_o;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    dual_slope_ctrl #(
        .AZ_CYCLES  (4),
        .INT_CYCLES (8),
        .MAX_DEINT  (20)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .start_i   (start_i),
        .cmp_i     (cmp_i),
        .sw_az_o   (sw_az_o),
        .sw_vin_o  (sw_vin_o),
        .sw_vref_o (sw_vref_o),
        .cnt_clr_o (cnt_clr_o),
        .cnt_en_o  (cnt_en_o),
        .result_o  (result_o),
        .valid_o   (valid_o),
        .busy_o    (busy_o),
        .ovr_o     (ovr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cmp_n;
        bit          xstart;
        logic [15:0] exp_res;
        bit          exp_ovr;
        int          exp_vref;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Invariants sampled on the falling edge every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ($countones({sw_az_o, sw_vin_o, sw_vref_o}) > 1) begin
                failures++;
                $display("FAIL switch_onehot: az=%0b vin=%0b vref=%0b", sw_az_o, sw_vin_o, sw_vref_o);
            end
            checks++;
            if (busy_o !== (dut.state != S_IDLE)) begin
                failures++;
                $display("FAIL busy_vs_state: busy=%0b state=%0d", busy_o, dut.state);
            end
        end
    end

    task automatic run_conv(input int cmp_n, input bit xstart, input logic [15:0] exp_res,
                            input bit exp_ovr, input int exp_vref);
        int az = 0, vin = 0, vref = 0, gap = 0, clr = 0, val = 0, post = 0, idx = 0;
        bit xs_done = 1'b0;
        logic [15:0] res = '0;
        logic ov = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b1;
        cmp_i   = (cmp_n > 0);
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (xstart && sw_vin_o && !xs_done) begin
                start_i = 1'b1;
                xs_done = 1'b1;
            end
            az   += int'(sw_az_o);
            vin  += int'(sw_vin_o);
            vref += int'(sw_vref_o);
            clr  += int'(cnt_clr_o);
            if (busy_o && !valid_o && !sw_az_o && !sw_vin_o && !sw_vref_o) gap++;
            if (sw_vref_o) begin
                cmp_i = (idx < cmp_n);
                idx++;
            end
            if (valid_o) begin
                val++;
                res = result_o;
                ov  = ovr_o;
            end
            if (val > 0 && !busy_o) post++;
            if (post >= 4) break;
        end
        check("conv_timeout", int'(post >= 4), 1);
        check("az_cycles", az, 4);
        check("int_cycles", vin, 8);
        check("gap_cycles", gap, 2);
        check("cnt_clr_pulses", clr, 1);
        check("deint_cycles", vref, exp_vref);
        check("valid_pulses", val, 1);
        check("result", int'(res), int'(exp_res));
        check("ovr", int'(ov), int'(exp_ovr));
        check("result_hold", int'(result_o), int'(exp_res));
        check("ovr_hold", int'(ovr_o), int'(exp_ovr));
    endtask

    initial begin
`ifdef DUAL_SLOPE_CMP_SYNC_EN
        vecs[0] = '{5,    1'b0, 16'd7,  1'b0, 8};
        vecs[1] = '{1000, 1'b0, 16'd20, 1'b1, 21};
        vecs[2] = '{0,    1'b1, 16'd0,  1'b0, 1};
        vecs[3] = '{3,    1'b0, 16'd5,  1'b0, 6};
        vecs[4] = '{20,   1'b0, 16'd20, 1'b1, 21};
        vecs[5] = '{19,   1'b0, 16'd20, 1'b1, 21};
`else
        vecs[0] = '{5,    1'b0, 16'd5,  1'b0, 6};
        vecs[1] = '{1000, 1'b0, 16'd20, 1'b1, 21};
        vecs[2] = '{0,    1'b1, 16'd0,  1'b0, 1};
        vecs[3] = '{3,    1'b0, 16'd3,  1'b0, 4};
        vecs[4] = '{20,   1'b0, 16'd20, 1'b1, 21};
        vecs[5] = '{19,   1'b0, 16'd19, 1'b0, 20};
`endif
        rst_ni  = 1'b0;
        start_i = 1'b0;
        cmp_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy_o), 0);
        check("rst_outputs", int'({sw_az_o, sw_vin_o, sw_vref_o, cnt_clr_o, cnt_en_o, valid_o, ovr_o}), 0);
        check("rst_result", int'(result_o), 0);
        rst_ni = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 6; i++)
            run_conv(vecs[i].cmp_n, vecs[i].xstart, vecs[i].exp_res, vecs[i].exp_ovr, vecs[i].exp_vref);

        // Abort during the integrate phase; result_o currently holds a nonzero value.
        begin
            int waited = 0;
            int val = 0;
            int busy_seen = 0;
            @(posedge clk); #1;
            start_i = 1'b1;
            cmp_i   = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
            while (!sw_vin_o && waited < 50) begin
                @(posedge clk); #1;
                waited++;
            end
            check("reach_int", int'(sw_vin_o), 1);
            @(posedge clk); #1;
            rst_ni = 1'b0;
            @(posedge clk); #1;
            check("abort_busy", int'(busy_o), 0);
            check("abort_switches", int'({sw_az_o, sw_vin_o, sw_vref_o}), 0);
            check("abort_cnt", int'({cnt_clr_o, cnt_en_o, valid_o, ovr_o}), 0);
            check("abort_result", int'(result_o), 0);
            rst_ni = 1'b1;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk); #1;
                val       += int'(valid_o);
                busy_seen += int'(busy_o);
            end
            check("abort_no_valid", val, 0);
            check("abort_stays_idle", busy_seen, 0);
            check("abort_result_hold", int'(result_o), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
